clk_rst_seq_ctrl: RTL
=====================

Name: clk_rst_seq_ctrl

Overview:
- Power-up and recovery sequencer for the board clocking/reset datapath.
- Runs on the raw board clock, ahead of the DCM. Sequences the DCM reset, waits for lock with timeout/retry, then holds the Ethernet PHY reset for a fixed time, waits a settle time, and releases the core reset.
- Monitors lock afterwards and re-runs the sequence on loss of lock. Replaces the ad-hoc DCM reset equation and free-running PHY reset at top level.

Parameters:
- DCM_RST_CYCLES, 16, cycles dcm_rst is held high per attempt (>=3).
- LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before a retry.
- PHY_RST_CYCLES, 1000000, cycles phy_reset_n is held low (10 ms at 100 MHz).
- PHY_SETTLE_CYCLES, 500000, cycles after PHY reset release before core release.
- RETRY_MAX, 3, lock attempts allowed before FAULT.
- CNT_W, 24, width of the shared cycle counter; must hold max(all cycle params)-1.

Ports:
- clk, input, 1: board clock (100 MHz, pre-DCM).
- reset_n, input, 1: asynchronous active-low reset.
- dcm_locked, input, 1: DCM LOCKED; asynchronous, synchronized internally.
- dcm_clkfx_stopped, input, 1: DCM STATUS[2]; asynchronous, synchronized internally.
- phy_reset_req, input, 1: single-cycle pulse requesting a PHY-only reset, honoured in RUN only.
- dcm_rst, output, 1: DCM RST.
- phy_reset_n, output, 1: PHY reset, active low.
- core_rst, output, 1: core reset, active high. Re-synchronized into the DCM clock domain by the existing sync_reset.
- ready, output, 1: high only in RUN.
- fault, output, 1: high only in FAULT.
- retry_cnt, output, 2: number of failed lock attempts in the current sequence.
- state, output, 3: current state encoding.

Behaviour:
- Synchronizers: dcm_locked and dcm_clkfx_stopped each pass through 2 flops (lock_s, stop_s), giving 2 cycles of latency. The synchronizer flops reset to 0.
- States and encoding: DCM_RST=0, WAIT_LOCK=1, PHY_RST=2, PHY_SETTLE=3, RUN=4, FAULT=5.
- Counter: one counter, cleared to 0 on every state entry and incremented each cycle in timed states. "Expires" means cnt==N-1, so a timed state lasts exactly N cycles.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- Values by state (dcm_rst / phy_reset_n / core_rst / ready / fault):
  - DCM_RST: 1/0/1/0/0
  - WAIT_LOCK: 0/0/1/0/0
  - PHY_RST: 0/0/1/0/0
  - PHY_SETTLE: 0/1/1/0/0
  - RUN: 0/1/0/1/0
  - FAULT: 1/0/1/0/1
- Reset (async, reset_n=0): state=DCM_RST, cnt=0, retry_cnt=0, dcm_rst=1, phy_reset_n=0, core_rst=1, ready=0, fault=0.
- DCM_RST: on expiry of DCM_RST_CYCLES, go to WAIT_LOCK.
- WAIT_LOCK, in priority order:
  - lock_s=1: go to PHY_RST. Lock is sampled from the first WAIT_LOCK cycle.
  - stop_s=1 and lock_s=0: failed attempt.
  - cnt==LOCK_TIMEOUT-1: failed attempt.
- Failed attempt:
  - If retry_cnt==RETRY_MAX-1: go to FAULT, and retry_cnt saturates at RETRY_MAX-1.
  - Otherwise: retry_cnt+=1 and go to DCM_RST.
- PHY_RST: on expiry, go to PHY_SETTLE.
- PHY_SETTLE: on expiry, go to RUN and clear retry_cnt.
- Lock loss: lock_s=0 in PHY_RST, PHY_SETTLE or RUN goes to DCM_RST immediately. It is not counted as a retry, and the counter is discarded.
- RUN:
  - phy_reset_req=1 goes to PHY_RST; the DCM is not reset.
  - If lock loss and phy_reset_req occur in the same cycle, lock loss wins (go to DCM_RST).
  - phy_reset_req is ignored in all other states.
- FAULT is terminal until reset_n is asserted; lock inputs are ignored there.
- Any reset_n assertion mid-sequence returns to the reset values asynchronously. The sequence restarts from DCM_RST on the first clk edge after deassertion.
- No combinational path from any input to any output.

Test Plan (DCM_RST_CYCLES=4, LOCK_TIMEOUT=16, PHY_RST_CYCLES=8, PHY_SETTLE_CYCLES=6, RETRY_MAX=3):
- Nominal:
  - Stimulus: release reset; raise dcm_locked 2 cycles after dcm_rst falls.
  - Required: dcm_rst high for exactly 4 cycles. state=2 four cycles after dcm_rst falls (entry at WAIT_LOCK cycle 2, plus 2-cycle synchronizer). phy_reset_n low for exactly 8 cycles in PHY_RST. core_rst falls and ready rises 6 cycles after phy_reset_n rises. retry_cnt=0.
- Timeout/retry:
  - Stimulus: dcm_locked held 0.
  - Required: three DCM_RST pulses of 4 cycles, each separated by 16 WAIT_LOCK cycles. retry_cnt steps 0→1→2. Then state=5, fault=1, dcm_rst=1 and phy_reset_n=0 held indefinitely.
- Clkfx stopped:
  - Stimulus: in WAIT_LOCK cycle 5, pulse dcm_clkfx_stopped=1 with lock=0.
  - Required: DCM_RST re-entered 2 cycles later (well before the 16-cycle timeout); retry_cnt=1.
- Lock loss:
  - Stimulus: in RUN, drop dcm_locked for 3 cycles; in the same cycle as the synchronized drop, also pulse phy_reset_req.
  - Required: state→0 two cycles after the drop. core_rst=1, ready=0, phy_reset_n=0. Full sequence reruns; retry_cnt stays 0.
- PHY-only reset:
  - Stimulus: in RUN, pulse phy_reset_req.
  - Required: dcm_rst stays 0. phy_reset_n low for 8 cycles, core_rst high for 14 cycles, then back to RUN.
- Mid-sequence reset:
  - Stimulus: assert reset_n low asynchronously during PHY_SETTLE (between clock edges).
  - Required: outputs reach reset values with no clk edge. After release, the sequence restarts with a 4-cycle dcm_rst.

Source files
------------

// File: rtl/clk_rst_seq_ctrl.sv
// Power-up / recovery sequencer on the raw board clock: DCM reset with lock timeout and retry,
// PHY reset hold, settle delay, core reset release, and re-sequencing on loss of DCM lock.
module clk_rst_seq_ctrl #(
   parameter int unsigned DCM_RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT      = 65536,
   parameter int unsigned PHY_RST_CYCLES    = 1000000,
   parameter int unsigned PHY_SETTLE_CYCLES = 500000,
   parameter int unsigned RETRY_MAX         = 3,
   parameter int unsigned CNT_W             = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       dcm_locked,
   input  logic       dcm_clkfx_stopped,
   input  logic       phy_reset_req,
   output logic       dcm_rst,
   output logic       phy_reset_n,
   output logic       core_rst,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_DCM_RST    = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_PHY_RST    = 3'd2,
      ST_PHY_SETTLE = 3'd3,
      ST_RUN        = 3'd4,
      ST_FAULT      = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_LAST  = 2'(RETRY_MAX - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       retry_q, retry_d;
   logic             fail;
   logic             lock_meta_q, lock_s_q, stop_meta_q, stop_s_q;
   logic             dcm_rst_q, phy_reset_n_q, core_rst_q, ready_q, fault_q;
   logic             dcm_rst_d, phy_reset_n_d, core_rst_d, ready_d, fault_d;

   // Two-flop synchronizers for the asynchronous DCM status inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: clocked blocks use <= so every flop samples the values from before the edge.
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         stop_meta_q <= 1'b0;
         stop_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= dcm_locked;
         lock_s_q    <= lock_meta_q;
         stop_meta_q <= dcm_clkfx_stopped;
         stop_s_q    <= stop_meta_q;
      end
   end

   always_comb begin
      // NOTE: every _d signal gets a default first so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;
      fail    = 1'b0;
      case (state_q)
         ST_DCM_RST:
            if (cnt_q == DCM_LAST) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK:
            if (lock_s_q)                          state_d = ST_PHY_RST;
            else if (stop_s_q || cnt_q == LOCK_LAST) fail  = 1'b1;
         ST_PHY_RST:
            if (!lock_s_q)              state_d = ST_DCM_RST;
            else if (cnt_q == PHY_LAST) state_d = ST_PHY_SETTLE;
         ST_PHY_SETTLE:
            if (!lock_s_q) state_d = ST_DCM_RST;
            else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
               retry_d = '0;
            end
         ST_RUN:
            if (!lock_s_q)          state_d = ST_DCM_RST;
            else if (phy_reset_req) state_d = ST_PHY_RST;
         ST_FAULT: ;
         default: state_d = ST_DCM_RST;
      endcase

      // A failed lock attempt either retries the DCM reset or gives up with retry_cnt saturated.
      if (fail) begin
         if (retry_q == RETRY_LAST) begin
            state_d = ST_FAULT;
         end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_DCM_RST;
         end
      end

      if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAULT) cnt_d = '0;

      // Outputs decode the next state so they switch on the same edge as state.
      dcm_rst_d     = (state_d == ST_DCM_RST) || (state_d == ST_FAULT);
      phy_reset_n_d = (state_d == ST_PHY_SETTLE) || (state_d == ST_RUN);
      core_rst_d    = (state_d != ST_RUN);
      ready_d       = (state_d == ST_RUN);
      fault_d       = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_DCM_RST;
         cnt_q         <= '0;
         retry_q       <= '0;
         dcm_rst_q     <= 1'b1;
         phy_reset_n_q <= 1'b0;
         core_rst_q    <= 1'b1;
         ready_q       <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         dcm_rst_q     <= dcm_rst_d;
         phy_reset_n_q <= phy_reset_n_d;
         core_rst_q    <= core_rst_d;
         ready_q       <= ready_d;
         fault_q       <= fault_d;
      end
   end

   assign state       = state_q;
   assign retry_cnt   = retry_q;
   assign dcm_rst     = dcm_rst_q;
   assign phy_reset_n = phy_reset_n_q;
   assign core_rst    = core_rst_q;
   assign ready       = ready_q;
   assign fault       = fault_q;

endmodule
